uart_word_tx: RTL

// Parametrised UART word transmitter in the clkout (bit-rate) domain. Pulls WORD_W-bit words from a

---
 rtl/uart_word_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_word_tx.sv
// UART word transmitter: pulls WORD_W-bit words from a non-show-ahead FIFO and
// sends them as WORD_W/8 back-to-back frames with optional parity and 1/2 stop bits.
module uart_word_tx #(
    parameter int WORD_W       = 16,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic              clkout,
    input  logic              reset_ayn,
    input  logic              enable,
    input  logic [WORD_W-1:0] fifo_q,
    input  logic              fifo_rdempty,
    output logic              fifo_rdreq,
    output logic              tx,
    output logic              busy,
    output logic              word_done
);
    localparam int NB = WORD_W / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (WORD_W < 8 || (WORD_W % 8) != 0) begin : g_bad_width
            $error("uart_word_tx: WORD_W must be a multiple of 8 and >= 8");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_cpb
            $error("uart_word_tx: CLKS_PER_BIT must be >= 1");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_word_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_word_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        PAR   = 3'd5,
        STOP  = 3'd6
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     baud_cnt, baud_nxt;
    logic [2:0]        bit_cnt, bit_nxt;
    logic [BW-1:0]     byte_idx, byte_nxt;
    logic [WORD_W-1:0] word_reg, word_nxt;
    logic [7:0]        cur_byte;
    logic              bit_end;
    logic              tx_nxt, rdreq_nxt, busy_nxt, done_nxt;

    function automatic logic [7:0] pick_byte(input logic [WORD_W-1:0] w,
                                             input logic [BW-1:0]     k);
        logic [WORD_W-1:0] sh;
        int                pos;
        pos = (MSB_FIRST != 0) ? (NB - 1 - int'(k)) : int'(k);
        sh  = w >> (8 * pos);
        return sh[7:0];
    endfunction

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        byte_nxt  = byte_idx;
        word_nxt  = word_reg;

        if (state inside {START, DATA, PAR, STOP})
            baud_nxt = bit_end ? '0 : baud_cnt + 1'b1;

        unique case (state)
            IDLE: if (enable && !fifo_rdempty) state_nxt = REQ;
            REQ:  state_nxt = LOAD;
            LOAD: begin
                word_nxt  = fifo_q;
                byte_nxt  = '0;
                baud_nxt  = '0;
                bit_nxt   = '0;
                state_nxt = START;
            end
            START: if (bit_end) state_nxt = DATA;
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PAR: if (bit_end) state_nxt = STOP;
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_nxt = '0;
                        // bytes of one word run back to back; only the word end returns to IDLE
                        if (byte_idx == BYTE_LAST) begin
                            byte_nxt  = '0;
                            state_nxt = IDLE;
                        end else begin
                            byte_nxt  = byte_idx + 1'b1;
                            state_nxt = START;
                        end
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        cur_byte  = pick_byte(word_nxt, byte_nxt);
        tx_nxt    = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = cur_byte[bit_nxt];
            PAR:     tx_nxt = (^cur_byte) ^ (PARITY == 1);
            default: tx_nxt = 1'b1;
        endcase
        rdreq_nxt = (state_nxt == REQ);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state == STOP) && (state_nxt == IDLE);
    end

    always_ff @(posedge clkout or negedge reset_ayn) begin
        if (!reset_ayn) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            word_reg   <= '0;
            tx         <= 1'b1;
            fifo_rdreq <= 1'b0;
            busy       <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_cnt    <= bit_nxt;
            byte_idx   <= byte_nxt;
            word_reg   <= word_nxt;
            tx         <= tx_nxt;
            fifo_rdreq <= rdreq_nxt;
            busy       <= busy_nxt;
            word_done  <= done_nxt;
        end
    end

endmodule
